// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM state encoding, the opcode map and the response record.
package alu_arb_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_LESS = 3'd6;
    localparam logic [2:0] OP_EQU  = 3'd7;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] result;
        logic              overflow;
        logic              zero;
        logic              carry;
    } rsp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and its consumer.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_arbiter_if;
    import alu_arb_pkg::*;

    logic              req0_valid;
    logic              req1_valid;
    logic [2:0]        req0_op;
    logic [2:0]        req1_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              req0_ready;
    logic              req1_ready;
    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_overflow;
    logic              rsp_zero;
    logic              rsp_carry;
    logic              rsp_ready;
    logic              busy;

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op,
               req0_a, req0_b, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result,
               rsp_overflow, rsp_zero, rsp_carry, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op,
               req0_a, req0_b, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result,
               rsp_overflow, rsp_zero, rsp_carry, busy
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 4-bit ALU. Flags only for add/sub; a signed overflow forces the
// result to 0, zero reflects the raw 4-bit sum/difference, carry is carry/borrow.
module alu
    import alu_arb_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              zero,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        result   = '0;
        overflow = 1'b0;
        zero     = 1'b0;
        carry    = 1'b0;
        case (op)
            OP_ADD: begin
                overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
                carry    = sum[DATA_W];
                zero     = (sum[DATA_W-1:0] == '0);
                result   = overflow ? '0 : sum[DATA_W-1:0];
            end
            OP_SUB: begin
                overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
                carry    = diff[DATA_W];
                zero     = (diff[DATA_W-1:0] == '0);
                result   = overflow ? '0 : diff[DATA_W-1:0];
            end
            OP_NOT:  result = ~a;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_LESS: result = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_EQU:  result = {{(DATA_W-1){1'b0}}, (a == b)};
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for one ALU: grants a requester, executes its op from
// latched operands, then holds the response until the consumer takes it.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    state_t            state_q;
    state_t            state_d;
    logic              last_id_q;
    logic              id_q;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    rsp_t              rsp_q;
    logic              any_valid;
    logic              grant_id;
    logic              take;
    logic [DATA_W-1:0] alu_result;
    logic              alu_overflow;
    logic              alu_zero;
    logic              alu_carry;

    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign take      = (state_q == ST_IDLE) && any_valid;

    // Contention goes to whoever was not served last (round robin) or to req0.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = RR_ENABLE ? ~last_id_q : 1'b0;
        end else begin
            grant_id = bus.req1_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every register sees pre-edge values.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = rst_n && take && !grant_id;
        bus.req1_ready = rst_n && take &&  grant_id;
        bus.busy       = (state_q != ST_IDLE);
        bus.rsp_valid  = (state_q == ST_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: operand and response registers are reset too, so a discarded op leaves nothing behind.
        if (!rst_n) begin
            last_id_q <= 1'b1;
            id_q      <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_q     <= '0;
        end else begin
            if (take) begin
                last_id_q <= grant_id;
                id_q      <= grant_id;
                op_q      <= grant_id ? bus.req1_op : bus.req0_op;
                a_q       <= grant_id ? bus.req1_a  : bus.req0_a;
                b_q       <= grant_id ? bus.req1_b  : bus.req0_b;
            end
            if (state_q == ST_EXEC) begin
                rsp_q <= '{id: id_q, result: alu_result, overflow: alu_overflow,
                           zero: alu_zero, carry: alu_carry};
            end
        end
    end

    assign bus.rsp_id       = rsp_q.id;
    assign bus.rsp_result   = rsp_q.result;
    assign bus.rsp_overflow = rsp_q.overflow;
    assign bus.rsp_zero     = rsp_q.zero;
    assign bus.rsp_carry    = rsp_q.carry;

    alu u_alu (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .result   (alu_result),
        .overflow (alu_overflow),
        .zero     (alu_zero),
        .carry    (alu_carry)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus
// and are compared every cycle against a transaction-level model, plus literal checks.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [2:0] req0_op, req1_op;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;

    always #5 clk = ~clk;

    alu_arbiter_if bus0 ();
    alu_arbiter_if bus1 ();

    assign bus0.req0_valid = req0_valid;  assign bus1.req0_valid = req0_valid;
    assign bus0.req1_valid = req1_valid;  assign bus1.req1_valid = req1_valid;
    assign bus0.req0_op    = req0_op;     assign bus1.req0_op    = req0_op;
    assign bus0.req1_op    = req1_op;     assign bus1.req1_op    = req1_op;
    assign bus0.req0_a     = req0_a;      assign bus1.req0_a     = req0_a;
    assign bus0.req0_b     = req0_b;      assign bus1.req0_b     = req0_b;
    assign bus0.req1_a     = req1_a;      assign bus1.req1_a     = req1_a;
    assign bus0.req1_b     = req1_b;      assign bus1.req1_b     = req1_b;
    assign bus0.rsp_ready  = rsp_ready;   assign bus1.rsp_ready  = rsp_ready;

    alu_arbiter #(.RR_ENABLE(1'b1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    alu_arbiter #(.RR_ENABLE(1'b0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    typedef struct {
        logic       r0, r1, busy, v, id;
        logic [3:0] res;
        logic       o, z, c;
    } obs_t;

    typedef struct {
        bit id;
        int res;
        bit o, z, c;
    } exp_rsp_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int sgn4(input int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    // Reference ALU in plain integer arithmetic.
    function automatic exp_rsp_t ref_alu(input int op, input int a, input int b, input bit id);
        exp_rsp_t r;
        int raw, s;
        r.id = id; r.res = 0; r.o = 0; r.z = 0; r.c = 0;
        case (op)
            0: begin
                raw = a + b; s = sgn4(a) + sgn4(b);
                r.c = (raw > 15); r.z = ((raw % 16) == 0); r.o = (s > 7 || s < -8);
                r.res = r.o ? 0 : raw % 16;
            end
            1: begin
                raw = a - b; s = sgn4(a) - sgn4(b);
                r.c = (a < b); r.z = (a == b); r.o = (s > 7 || s < -8);
                r.res = r.o ? 0 : (raw + 16) % 16;
            end
            2: r.res = 15 - a;
            3: r.res = a & b;
            4: r.res = a | b;
            5: r.res = a ^ b;
            6: r.res = (a < b) ? 1 : 0;
            default: r.res = (a == b) ? 1 : 0;
        endcase
        return r;
    endfunction

    // Model per instance: age -1 = free, 0 = op accepted, 1 = response on display.
    int       m_age   [2] = '{-1, -1};
    bit       m_last  [2] = '{1'b1, 1'b1};
    bit       m_clean [2] = '{1'b1, 1'b1};
    exp_rsp_t m_rsp   [2];
    exp_rsp_t m_pend  [2];
    obs_t     obs     [2];

    function automatic bit pick(input int k);
        if (req0_valid && req1_valid) return (k == 0) ? !m_last[k] : 1'b0;
        return req1_valid;
    endfunction

    always @(negedge clk) begin
        obs[0] = '{bus0.req0_ready, bus0.req1_ready, bus0.busy, bus0.rsp_valid, bus0.rsp_id,
                   bus0.rsp_result, bus0.rsp_overflow, bus0.rsp_zero, bus0.rsp_carry};
        obs[1] = '{bus1.req0_ready, bus1.req1_ready, bus1.busy, bus1.rsp_valid, bus1.rsp_id,
                   bus1.rsp_result, bus1.rsp_overflow, bus1.rsp_zero, bus1.rsp_carry};
        for (int k = 0; k < 2; k++) begin
            bit e_r0, e_r1, g;
            if (!rst_n) begin
                m_age[k] = -1; m_last[k] = 1'b1; m_clean[k] = 1'b1;
                m_rsp[k] = '{id: 1'b0, res: 0, o: 1'b0, z: 1'b0, c: 1'b0};
            end
            e_r0 = 1'b0; e_r1 = 1'b0;
            if (rst_n && m_age[k] < 0 && (req0_valid || req1_valid)) begin
                g = pick(k); e_r0 = !g; e_r1 = g;
            end
            check($sformatf("req0_ready[%0d]", k), 8'(obs[k].r0), 8'(e_r0));
            check($sformatf("req1_ready[%0d]", k), 8'(obs[k].r1), 8'(e_r1));
            check($sformatf("busy[%0d]", k), 8'(obs[k].busy), 8'(m_age[k] >= 0));
            check($sformatf("rsp_valid[%0d]", k), 8'(obs[k].v), 8'(m_age[k] == 1));
            if (m_age[k] == 1 || m_clean[k]) begin
                check($sformatf("rsp_id[%0d]", k), 8'(obs[k].id), 8'(m_rsp[k].id));
                check($sformatf("rsp_result[%0d]", k), 8'(obs[k].res), 8'(m_rsp[k].res));
                check($sformatf("rsp_overflow[%0d]", k), 8'(obs[k].o), 8'(m_rsp[k].o));
                check($sformatf("rsp_zero[%0d]", k), 8'(obs[k].z), 8'(m_rsp[k].z));
                check($sformatf("rsp_carry[%0d]", k), 8'(obs[k].c), 8'(m_rsp[k].c));
            end
            if (rst_n) begin
                if (m_age[k] < 0) begin
                    if (req0_valid || req1_valid) begin
                        g = pick(k);
                        m_last[k] = g;
                        m_pend[k] = g ? ref_alu(int'(req1_op), int'(req1_a), int'(req1_b), 1'b1)
                                      : ref_alu(int'(req0_op), int'(req0_a), int'(req0_b), 1'b0);
                        m_age[k] = 0;
                    end
                end else if (m_age[k] == 0) begin
                    m_age[k] = 1; m_rsp[k] = m_pend[k]; m_clean[k] = 1'b0;
                end else if (rsp_ready) begin
                    m_age[k] = -1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        exp_rsp_t r;
        int n_fp1, n_rr1, n_fp0;

        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

        // Pin the reference ALU with hand-computed values.
        r = ref_alu(0, 3, 2, 1'b0);   check("model_add_3_2", 8'(r.res), 8'd5);
        r = ref_alu(0, 4, 4, 1'b0);   check("model_add_ovf_res", 8'(r.res), 8'd0);
        check("model_add_ovf_flag", 8'(r.o), 8'd1);
        r = ref_alu(1, 2, 3, 1'b0);   check("model_sub_borrow", 8'(r.c), 8'd1);
        check("model_sub_res", 8'(r.res), 8'hF);

        // Reset state, with a request pending to show ready is held low.
        repeat (2) tick();
        req0_valid = 1'b1;
        @(negedge clk);
        check("rst_ready0", 8'(bus0.req0_ready), 8'd0);
        check("rst_busy", 8'(bus0.busy), 8'd0);
        check("rst_result", 8'(bus0.rsp_result), 8'd0);

        // Single request from req0: 3 + 2.
        tick();
        rst_n = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 4'd3; req0_b = 4'd2;
        @(negedge clk);
        check("t1_ready0", 8'(bus0.req0_ready), 8'd1);
        check("t1_ready1", 8'(bus0.req1_ready), 8'd0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("t1_exec_ready0", 8'(bus0.req0_ready), 8'd0);
        check("t1_exec_busy", 8'(bus0.busy), 8'd1);
        check("t1_exec_valid", 8'(bus0.rsp_valid), 8'd0);
        tick();
        @(negedge clk);
        check("t1_valid", 8'(bus0.rsp_valid), 8'd1);
        check("t1_id", 8'(bus0.rsp_id), 8'd0);
        check("t1_result", 8'(bus0.rsp_result), 8'd5);
        check("t1_overflow", 8'(bus0.rsp_overflow), 8'd0);
        check("t1_carry", 8'(bus0.rsp_carry), 8'd0);
        tick();
        @(negedge clk);
        check("t1_done_valid", 8'(bus0.rsp_valid), 8'd0);
        check("t1_done_busy", 8'(bus0.busy), 8'd0);

        // Contention straight after reset.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = OP_AND; req0_a = 4'hC; req0_b = 4'hA;
        req1_valid = 1'b1; req1_op = OP_EQU; req1_a = 4'h5; req1_b = 4'h5;
        @(negedge clk);
        check("c_rr_ready0", 8'(bus0.req0_ready), 8'd1);
        check("c_fp_ready0", 8'(bus1.req0_ready), 8'd1);
        tick(); tick();
        @(negedge clk);
        check("c_rr_id0", 8'(bus0.rsp_id), 8'd0);
        check("c_rr_res0", 8'(bus0.rsp_result), 8'h8);
        tick();
        @(negedge clk);
        check("c_rr_ready1", 8'(bus0.req1_ready), 8'd1);
        check("c_fp_ready1", 8'(bus1.req1_ready), 8'd0);
        tick(); tick();
        @(negedge clk);
        check("c_rr_id1", 8'(bus0.rsp_id), 8'd1);
        check("c_rr_res1", 8'(bus0.rsp_result), 8'h1);
        check("c_fp_id", 8'(bus1.rsp_id), 8'd0);
        n_fp1 = 0; n_rr1 = 0; n_fp0 = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            @(negedge clk);
            n_fp1 += int'(bus1.req1_ready);
            n_fp0 += int'(bus1.req0_ready);
            n_rr1 += int'(bus0.req1_ready);
        end
        check("c_fp_req1_grants", 8'(n_fp1), 8'd0);
        check("c_fp_req0_grants", 8'(n_fp0), 8'd4);
        check("c_rr_req1_grants", 8'(n_rr1), 8'd2);

        // Backpressure: response held for five cycles, requests stay unserved.
        tick();
        go_idle();
        req1_valid = 1'b1; req1_op = OP_OR; req1_a = 4'h4; req1_b = 4'h4; rsp_ready = 1'b0;
        tick();
        req1_valid = 1'b0;
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 8'(bus0.rsp_valid), 8'd1);
            check("bp_result", 8'(bus0.rsp_result), 8'h4);
            check("bp_flags", {5'd0, bus0.rsp_overflow, bus0.rsp_zero, bus0.rsp_carry}, 8'd0);
            check("bp_ready", {6'd0, bus0.req0_ready, bus0.req1_ready}, 8'd0);
            check("bp_busy", 8'(bus0.busy), 8'd1);
            tick();
        end
        rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        @(negedge clk);
        check("bp_release_busy", 8'(bus0.busy), 8'd0);
        check("bp_release_valid", 8'(bus0.rsp_valid), 8'd0);

        // Signed overflow on add.
        go_idle();
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 4'h4; req0_b = 4'h4;
        tick();
        req0_valid = 1'b0;
        tick();
        @(negedge clk);
        check("ovf_flag", 8'(bus0.rsp_overflow), 8'd1);
        check("ovf_result", 8'(bus0.rsp_result), 8'h0);

        // Reset while a response is displayed.
        go_idle();
        req0_valid = 1'b1; req0_op = OP_XOR; req0_a = 4'h5; req0_b = 4'h3; rsp_ready = 1'b0;
        tick();
        req0_valid = 1'b0;
        tick();
        @(negedge clk);
        check("mr_valid_before", 8'(bus0.rsp_valid), 8'd1);
        check("mr_result_before", 8'(bus0.rsp_result), 8'h6);
        tick();
        rst_n = 1'b0;
        #1;
        check("mr_valid_async", 8'(bus0.rsp_valid), 8'd0);
        check("mr_busy_async", 8'(bus0.busy), 8'd0);
        check("mr_result_async", 8'(bus0.rsp_result), 8'd0);
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_rr_ready0", 8'(bus0.req0_ready), 8'd1);
        check("mr_rr_ready1", 8'(bus0.req1_ready), 8'd0);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst_n      = ($urandom_range(0, 199) != 0);
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_op    = 3'($urandom);
            req1_op    = 3'($urandom);
            req0_a     = 4'($urandom);
            req0_b     = 4'($urandom);
            req1_a     = 4'($urandom);
            req1_b     = 4'($urandom);
            rsp_ready  = ($urandom_range(0, 9) < 7);
        end
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
